alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Registered issue stage directly upstream of the 16-bit ALU. It accepts decoded ALU operations (operands, 3-bit ALU control, destination register) from decode, and presents them to the ALU.
- A 2-entry skid buffer with valid/ready handshakes decouples decode from execute back-pressure.
- Writeback forwarding patches operands, both at capture and while an entry is held.
- Flush support covers branch redirect.

Parameters:
- DATA_W, 16, operand width; matches ALU a/b.
- REG_AW, 3, register-index width (8 architectural registers; r0 reads as zero).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  discard all buffered operations
- in_valid  input  1  decode presents an operation
- in_ready  output  1  stage can accept an operation
- in_a  input  DATA_W  operand A from register file
- in_b  input  DATA_W  operand B (register or immediate)
- in_rs1  input  REG_AW  source index for A
- in_rs2  input  REG_AW  source index for B
- in_b_is_reg  input  1  1 = in_b came from rs2 (forwardable); 0 = immediate
- in_ctrl  input  3  ALU control code, passed through unchanged
- in_rd  input  REG_AW  destination index, passed through
- fwd_valid  input  1  writeback is writing a register this cycle
- fwd_rd  input  REG_AW  writeback destination
- fwd_data  input  DATA_W  writeback value
- out_valid  output  1  ALU operation available
- out_ready  input  1  execute consumes the operation
- out_a  output  DATA_W  to ALU a
- out_b  output  DATA_W  to ALU b
- out_ctrl  output  3  to ALU control
- out_rd  output  REG_AW  destination to EX/MEM
- occupancy  output  2  entries held (0..2)

Behaviour:
- Reset (rst_n low, asynchronous): both entries invalid.
  - out_valid=0, occupancy=0, out_a/out_b/out_ctrl/out_rd=0.
  - in_ready=1 once reset deasserts.
- Storage: main entry (drives out_*) and skid entry. Each entry holds a, b, rs1, rs2, b_is_reg, ctrl, rd, valid.
- in_ready = NOT skid.valid, driven from registers only. There is no combinational path from out_ready or in_* to in_ready or out_*.
- Handshakes:
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - out_* stay stable while out_valid=1 and out_ready=0.
- Latency: an operation accepted at edge N appears on out_* after edge N (1 cycle), provided main is empty or is being consumed at edge N.
- Per-edge update, in priority order:
  - flush=1: both entries invalid. Any concurrent input fire is dropped. Any concurrent output fire still counts as consumed by execute.
  - Main empty, or main consumed this edge:
    - If skid is valid, skid moves to main. A concurrent input then goes to skid.
    - Otherwise, a concurrent input goes directly to main.
  - Main valid and not consumed: a concurrent input goes to skid.
  - Order is strictly FIFO. The skid entry is never older than main.
- Forwarding. A hit requires fwd_valid=1, fwd_rd != 0, and fwd_rd equal to the entry's source index. For operand B it also requires b_is_reg=1.
  - A hit replaces the operand with fwd_data.
  - It applies to the incoming operation at capture.
  - It applies to every held entry each edge, including the skid→main move.
  - rs1 and rs2 may both hit on the same edge; both are replaced.
  - Index 0 never forwards.
- occupancy = main.valid + skid.valid, registered.
- Reset asserted mid-operation drops all entries immediately, with no handshake completion.

Test Plan:
- Streaming: out_ready=1, 4 back-to-back ops (ctrl 000,001,101,111) -> each appears 1 cycle after acceptance, in order; in_ready stays 1; occupancy never exceeds 1.
- Back-pressure: out_ready=0, send ops X then Y -> occupancy=2, in_ready=0, out_* hold X. A third op Z held on in_valid is not accepted. Raise out_ready -> X, Y, Z emerge in order.
- Capture forward: op with in_rs1=3, in_a=0x0001, fwd_valid=1, fwd_rd=3, fwd_data=0xBEEF -> out_a=0xBEEF.
- Held-entry forward: op with rs2=5 (b_is_reg=1) stalled in skid; writeback rd=5, data 0x1234 -> out_b=0x1234 when it reaches main. Same case with b_is_reg=0 -> b unchanged. Case with fwd_rd=0 -> no forward.
- Flush: occupancy=2, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, incoming op discarded; following op issues normally.
- Async reset: assert rst_n=0 between clock edges with occupancy=2 -> out_valid=0 and occupancy=0 immediately; after release, in_ready=1.

Source files
------------

// File: rtl/alu_issue_if.sv
// Operation stream between decode, the ALU issue stage and execute.
// Both the decode-side and the ALU-side handshakes live in this bundle.
interface alu_issue_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic              in_b_is_reg;
  logic [2:0]        in_ctrl;
  logic [REG_AW-1:0] in_rd;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [2:0]        out_ctrl;
  logic [REG_AW-1:0] out_rd;

  modport slave (
    input  in_valid, in_a, in_b, in_rs1, in_rs2,
    input  in_b_is_reg, in_ctrl, in_rd,
    output in_ready,
    output out_valid, out_a, out_b, out_ctrl, out_rd,
    input  out_ready
  );

  modport master (
    output in_valid, in_a, in_b, in_rs1, in_rs2,
    output in_b_is_reg, in_ctrl, in_rd,
    input  in_ready,
    input  out_valid, out_a, out_b, out_ctrl, out_rd,
    output out_ready
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: 2-entry skid buffer in front of the ALU with
// writeback forwarding applied at capture and to held entries.
module alu_issue_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              fwd_valid,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [DATA_W-1:0] fwd_data,
  alu_issue_if.slave        bus,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              b_reg;
    logic [2:0]        ctrl;
    logic [REG_AW-1:0] rd;
  } op_t;

  op_t        main_q, main_d;
  op_t        skid_q, skid_d;
  logic       main_v_q, main_v_d;
  logic       skid_v_q, skid_v_d;
  logic [1:0] occ_q, occ_d;
  op_t        inc;
  logic       in_fire;
  logic       out_fire;

  // r0 is hard-wired zero, so a write to it never patches anything
  function automatic op_t fwd(input op_t o);
    op_t  r;
    logic hit;
    r   = o;
    hit = fwd_valid && (fwd_rd != '0);
    if (hit && fwd_rd == o.rs1)
      r.a = fwd_data;
    if (hit && o.b_reg && fwd_rd == o.rs2)
      r.b = fwd_data;
    return r;
  endfunction

  assign in_fire  = bus.in_valid & ~skid_v_q;
  assign out_fire = main_v_q & bus.out_ready;

  always_comb begin
    inc       = '0;
    inc.a     = bus.in_a;
    inc.b     = bus.in_b;
    inc.rs1   = bus.in_rs1;
    inc.rs2   = bus.in_rs2;
    inc.b_reg = bus.in_b_is_reg;
    inc.ctrl  = bus.in_ctrl;
    inc.rd    = bus.in_rd;
    inc       = fwd(inc);
  end

  always_comb begin
    main_d   = fwd(main_q);
    skid_d   = fwd(skid_q);
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || out_fire) begin
      // in_ready is low whenever skid is full, so no input competes here
      if (skid_v_q) begin
        main_d   = fwd(skid_q);
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = in_fire;
        if (in_fire)
          main_d = inc;
      end
    end else if (in_fire) begin
      skid_d   = inc;
      skid_v_d = 1'b1;
    end
    occ_d = {1'b0, main_v_d} + {1'b0, skid_v_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      occ_q    <= occ_d;
    end
  end

  assign bus.in_ready  = ~skid_v_q;
  assign bus.out_valid = main_v_q;
  assign bus.out_a     = main_q.a;
  assign bus.out_b     = main_q.b;
  assign bus.out_ctrl  = main_q.ctrl;
  assign bus.out_rd    = main_q.rd;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected ops are queued on
// acceptance and compared when the stage hands them to execute.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        fwd_valid = 1'b0;
  logic [2:0]  fwd_rd = '0;
  logic [15:0] fwd_data = '0;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  ctrl;
    logic [2:0]  rd;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];

  alu_issue_if #(.DATA_W(16), .REG_AW(3)) bus ();

  alu_issue_stage #(.DATA_W(16), .REG_AW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_a", {16'd0, bus.out_a}, {16'd0, e.a});
        check("out_b", {16'd0, bus.out_b}, {16'd0, e.b});
        check("out_ctrl", {29'd0, bus.out_ctrl}, {29'd0, e.ctrl});
        check("out_rd", {29'd0, bus.out_rd}, {29'd0, e.rd});
        if (e.lat)
          check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] rs1, input logic [2:0] rs2,
                      input logic bir, input logic [2:0] ctrl,
                      input logic [2:0] rd,
                      input logic [15:0] ea, input logic [15:0] eb,
                      input bit push, input bit lat);
    int   n;
    logic fl;
    exp_t e;
    bus.in_a        = a;
    bus.in_b        = b;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_b_is_reg = bir;
    bus.in_ctrl     = ctrl;
    bus.in_rd       = rd;
    bus.in_valid    = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 50)
      check("send_timeout", 32'd1, 32'd0);
    fl = flush;
    @(posedge clk);
    #1;
    if (push && !fl) begin
      e.a    = ea;
      e.b    = eb;
      e.ctrl = ctrl;
      e.rd   = rd;
      e.cyc  = cyc;
      e.lat  = lat;
      sb.push_back(e);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", sb.size(), 32'd0);
    @(posedge clk);
    #1;
    check("drain_occ", {30'd0, occupancy}, 32'd0);
  endtask

  task automatic held_case(input logic bir, input logic [2:0] frd,
                           input logic [2:0] ysrc,
                           input logic [15:0] exa,
                           input logic [15:0] eyb);
    bus.out_ready = 1'b0;
    send(16'h0A0A, 16'h0B0B, 3'd5, 3'd2, 1'b1, 3'b010, 3'd4,
         exa, 16'h0B0B, 1, 0);
    send(16'h0C0C, 16'h0055, 3'd1, ysrc, bir, 3'b011, 3'd6,
         16'h0C0C, eyb, 1, 0);
    check("held_occ", {30'd0, occupancy}, 32'd2);
    fwd_valid = 1'b1;
    fwd_rd    = frd;
    fwd_data  = 16'h1234;
    @(posedge clk);
    #1;
    fwd_valid = 1'b0;
    drain();
  endtask

  initial begin
    logic [2:0] ctrls [4];
    ctrls[0] = 3'b000;
    ctrls[1] = 3'b001;
    ctrls[2] = 3'b101;
    ctrls[3] = 3'b111;
    bus.in_valid    = 1'b0;
    bus.in_a        = '0;
    bus.in_b        = '0;
    bus.in_rs1      = '0;
    bus.in_rs2      = '0;
    bus.in_b_is_reg = 1'b0;
    bus.in_ctrl     = '0;
    bus.in_rd       = '0;
    bus.out_ready   = 1'b0;

    #2;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_occ", {30'd0, occupancy}, 32'd0);
    check("rst_a", {16'd0, bus.out_a}, 32'd0);
    check("rst_b", {16'd0, bus.out_b}, 32'd0);
    check("rst_ctrl", {29'd0, bus.out_ctrl}, 32'd0);
    check("rst_rd", {29'd0, bus.out_rd}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // streaming with ready held high
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(16'h1000 + 16'(i), 16'h2000 + 16'(i), 3'd1, 3'd2,
           1'b1, ctrls[i], 3'(i + 1),
           16'h1000 + 16'(i), 16'h2000 + 16'(i), 1, 1);
      check("strm_ready", {31'd0, bus.in_ready}, 32'd1);
      check("strm_occ_le1", {31'd0, occupancy <= 2'd1}, 32'd1);
    end
    drain();

    // back-pressure: X, Y fill the buffer, Z must wait
    bus.out_ready = 1'b0;
    send(16'hAAAA, 16'h0001, 3'd1, 3'd2, 1'b1, 3'b100, 3'd1,
         16'hAAAA, 16'h0001, 1, 0);
    send(16'hBBBB, 16'h0002, 3'd1, 3'd2, 1'b1, 3'b101, 3'd2,
         16'hBBBB, 16'h0002, 1, 0);
    check("bp_occ", {30'd0, occupancy}, 32'd2);
    check("bp_ready", {31'd0, bus.in_ready}, 32'd0);
    fork
      send(16'hCCCC, 16'h0003, 3'd1, 3'd2, 1'b1, 3'b110, 3'd3,
           16'hCCCC, 16'h0003, 1, 0);
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
          check("bp_hold_occ", {30'd0, occupancy}, 32'd2);
          check("bp_hold_a", {16'd0, bus.out_a}, 32'h0000AAAA);
          check("bp_hold_ctrl", {29'd0, bus.out_ctrl}, 32'd4);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // forwarding at capture
    fwd_valid = 1'b1;
    fwd_rd    = 3'd3;
    fwd_data  = 16'hBEEF;
    send(16'h0001, 16'h0002, 3'd3, 3'd4, 1'b1, 3'b000, 3'd1,
         16'hBEEF, 16'h0002, 1, 1);
    send(16'h0001, 16'h0002, 3'd3, 3'd3, 1'b1, 3'b001, 3'd2,
         16'hBEEF, 16'hBEEF, 1, 1);
    send(16'h0001, 16'h0002, 3'd3, 3'd3, 1'b0, 3'b010, 3'd3,
         16'hBEEF, 16'h0002, 1, 1);
    fwd_rd = 3'd0;
    send(16'h0007, 16'h0008, 3'd0, 3'd0, 1'b1, 3'b011, 3'd4,
         16'h0007, 16'h0008, 1, 1);
    fwd_valid = 1'b0;
    drain();

    // forwarding into held entries
    held_case(1'b1, 3'd5, 3'd5, 16'h1234, 16'h1234);
    held_case(1'b0, 3'd5, 3'd5, 16'h1234, 16'h0055);
    held_case(1'b1, 3'd0, 3'd0, 16'h0A0A, 16'h0055);

    // flush with both entries full and a concurrent input
    bus.out_ready = 1'b0;
    send(16'h1111, 16'h0, 3'd1, 3'd2, 1'b1, 3'b000, 3'd1,
         16'h0, 16'h0, 0, 0);
    send(16'h2222, 16'h0, 3'd1, 3'd2, 1'b1, 3'b000, 3'd2,
         16'h0, 16'h0, 0, 0);
    check("fl_occ_pre", {30'd0, occupancy}, 32'd2);
    bus.in_a     = 16'h3333;
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fl_occ", {30'd0, occupancy}, 32'd0);
    check("fl_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    send(16'h4444, 16'h5555, 3'd1, 3'd2, 1'b1, 3'b111, 3'd7,
         16'h4444, 16'h5555, 1, 1);
    drain();

    // asynchronous reset between edges
    bus.out_ready = 1'b0;
    send(16'h6666, 16'h0, 3'd1, 3'd2, 1'b1, 3'b000, 3'd1,
         16'h0, 16'h0, 0, 0);
    send(16'h7777, 16'h0, 3'd1, 3'd2, 1'b1, 3'b000, 3'd2,
         16'h0, 16'h0, 0, 0);
    check("ar_occ_pre", {30'd0, occupancy}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, bus.out_valid}, 32'd0);
    check("ar_occ", {30'd0, occupancy}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("ar_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(16'h8888, 16'h9999, 3'd1, 3'd2, 1'b1, 3'b101, 3'd5,
         16'h8888, 16'h9999, 1, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
